// File: rtl/phy_tx_stripe.sv
// Single-clock serial transmit path: DATA_W-bit words are striped byte-wise across
// LANES lanes, each lane shifting 8-bit symbols MSB first and idling on IDLE_SYM.
module phy_tx_stripe #(
  parameter int         DATA_W   = 32,
  parameter int         LANES    = 2,
  parameter logic [7:0] IDLE_SYM = 8'hBC
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_in,
  output logic [LANES-1:0]  data_out,
  output logic              active,
  output logic              sym_start
);

  localparam int STRIPE_W = 8 * LANES;
  localparam int BPL      = DATA_W / STRIPE_W;
  localparam int SLOT_W   = (BPL > 1) ? $clog2(BPL) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(BPL - 1);

  logic [2:0]              bit_cnt_q, bit_cnt_d;
  logic [LANES-1:0][7:0]   sh_q, sh_d;
  logic [DATA_W-1:0]       buf_q, buf_d;
  logic                    buf_full_q, buf_full_d;
  logic [DATA_W-1:0]       cur_q, cur_d;
  logic [SLOT_W-1:0]       slot_q, slot_d;
  logic                    cur_valid_q, cur_valid_d;
  logic [DATA_W-1:0]       cur_next;
  logic                    accept;

  assign accept    = valid_in && !buf_full_q;
  assign ready_in  = !buf_full_q;
  assign active    = cur_valid_q;
  assign sym_start = (bit_cnt_q == 3'd0);

  always_comb begin
    data_out = '0;
    for (int i = 0; i < LANES; i++) data_out[i] = sh_q[i][7];
  end

  // cur is kept left-aligned: each advanced slot shifts the next stripe to the top.
  assign cur_next = cur_q << STRIPE_W;

  always_comb begin
    // NOTE: every next-state signal gets a default here so no path leaves it
    // unassigned, which would otherwise infer a latch.
    bit_cnt_d   = bit_cnt_q + 3'd1;
    sh_d        = sh_q;
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    cur_d       = cur_q;
    slot_d      = slot_q;
    cur_valid_d = cur_valid_q;

    // Accept never collides with a load: load needs buf_full, accept needs !buf_full.
    if (accept) begin
      buf_d      = data_in;
      buf_full_d = 1'b1;
    end

    if (bit_cnt_q == 3'd7) begin
      if (cur_valid_q && (slot_q < LAST_SLOT)) begin
        slot_d = slot_q + 1'b1;
        cur_d  = cur_next;
        for (int i = 0; i < LANES; i++) sh_d[i] = cur_next[DATA_W-1-8*i -: 8];
      end else if (buf_full_q) begin
        cur_d       = buf_q;
        cur_valid_d = 1'b1;
        slot_d      = '0;
        buf_full_d  = 1'b0;
        for (int i = 0; i < LANES; i++) sh_d[i] = buf_q[DATA_W-1-8*i -: 8];
      end else begin
        cur_valid_d = 1'b0;
        slot_d      = '0;
        sh_d        = {LANES{IDLE_SYM}};
      end
    end else begin
      for (int i = 0; i < LANES; i++) sh_d[i] = {sh_q[i][6:0], 1'b0};
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      bit_cnt_q   <= 3'd0;
      sh_q        <= {LANES{IDLE_SYM}};
      buf_full_q  <= 1'b0;
      cur_valid_q <= 1'b0;
      slot_q      <= '0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      sh_q        <= sh_d;
      buf_full_q  <= buf_full_d;
      cur_valid_q <= cur_valid_d;
      slot_q      <= slot_d;
    end
  end

  // NOTE: the word storage is not reset; its contents are only ever used while
  // buf_full_q/cur_valid_q mark them valid, and those flags are reset.
  always_ff @(posedge clk_32f) begin
    buf_q <= buf_d;
    cur_q <= cur_d;
  end

endmodule
